mfp_ahb_lite_slave_frontend: RTL and testbench

Parametrised AHB-Lite slave front-end placed between the bus matrix and a synchronous single-port-style RAM or register block (one read port, one write port). It supports 32- or 64-bit data, programmable wait states, byte-lane masks for any legal HSIZE, a two-cycle ERROR response for illegal transfers, and read-after-write forwarding so the RAM never returns stale data. It drives HREADYOUT/HRESP/HRDATA directly, and the memory stays a plain sync-read array.

---
 rtl/mfp_ahb_lite_slave_frontend.sv | 105 ++++++++++
 tb/tb_mfp_ahb_lite_slave_frontend.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_lite_slave_frontend.sv
// mfp_ahb_lite_slave_frontend: AHB-Lite slave front-end for a sync-read RAM with wait states, byte lanes, ERROR and RAW forwarding
// Ports: HCLK/HRESETn clock and async active-low reset; HADDR/HSIZE/HTRANS/HWRITE/HSEL/HREADY address phase;
//        HWDATA/HRDATA/HREADYOUT/HRESP data phase; mem_read_* one-cycle-latency read port; mem_write_* registered write port.
module mfp_ahb_lite_slave_frontend #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_STATES = 0,
    parameter bit ERR_ON_MISALIGN = 1'b1,
    localparam int BYTES = DATA_WIDTH / 8,
    localparam int LSB = $clog2(BYTES),
    localparam int WAW = ADDR_WIDTH - LSB
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  mem_read_enable,
    output logic [WAW-1:0]        mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_write_enable,
    output logic [WAW-1:0]        mem_write_addr,
    output logic [BYTES-1:0]      mem_write_mask,
    output logic [DATA_WIDTH-1:0] mem_write_data
);
    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
    state_t state;
    logic [LSB-1:0] lo, size_m, off;
    logic [BYTES-1:0] mask, cap_mask, fwd_mask;
    logic [WAW-1:0] word, cap_addr;
    logic legal, accept, misalign, cap_read, cap_write, hit_new, hit_old;
    logic [2:0] cnt;
    logic [DATA_WIDTH-1:0] fwd_data, fwd_bits, new_bits;

    function automatic logic [DATA_WIDTH-1:0] lanes(input logic [BYTES-1:0] m);
        for (int i = 0; i < BYTES; i++) lanes[i*8 +: 8] = {8{m[i]}};
    endfunction

    always_comb begin
        lo = HADDR[LSB-1:0];
        size_m = LSB'((32'd1 << HSIZE) - 32'd1);
        off = lo & ~size_m;
        misalign = |(lo & size_m);
        mask = BYTES'(((32'd1 << (32'd1 << HSIZE)) - 32'd1) << off);
        legal = (HSIZE <= 3'(LSB)) && !(ERR_ON_MISALIGN && misalign);
        accept = HRESETn && HSEL && (HTRANS == 2'b10 || HTRANS == 2'b11) && HREADY && (state == IDLE || state == DATA);
        word = HADDR[ADDR_WIDTH-1:LSB];
        // zero-wait reads go out in the address phase; otherwise in the last wait cycle
        mem_read_enable = (WAIT_STATES == 0) ? accept && legal && !HWRITE : state == WAIT && cnt == 3'd0 && cap_read;
        mem_read_addr = (WAIT_STATES == 0) ? word : cap_addr;
        // hit_new: a read issued while the write to the same word is still in its data phase
        hit_new = mem_read_enable && state == DATA && cap_write && cap_addr == mem_read_addr;
        // hit_old: a read colliding with the write being committed this cycle
        hit_old = mem_read_enable && mem_write_enable && mem_write_addr == mem_read_addr;
        new_bits = lanes(cap_mask);
        fwd_bits = lanes(fwd_mask);
        HREADYOUT = !(state == WAIT || state == ERR1);
        HRESP = state == ERR1 || state == ERR2;
        HRDATA = (state == DATA && cap_read) ? (fwd_data & fwd_bits) | (mem_read_data & ~fwd_bits) : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
            cnt <= '0;
            cap_addr <= '0;
            cap_mask <= '0;
            cap_read <= 1'b0;
            cap_write <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_write_addr <= '0;
            mem_write_mask <= '0;
            mem_write_data <= '0;
            fwd_mask <= '0;
            fwd_data <= '0;
        end else begin
            mem_write_enable <= state == DATA && cap_write;
            if (state == DATA && cap_write) begin
                mem_write_addr <= cap_addr;
                mem_write_mask <= cap_mask;
                mem_write_data <= HWDATA;
            end
            fwd_mask <= (hit_old ? mem_write_mask : '0) | (hit_new ? cap_mask : '0);
            fwd_data <= hit_new ? (HWDATA & new_bits) | (mem_write_data & ~new_bits) : mem_write_data;
            if (accept) begin
                cap_addr <= word;
                cap_mask <= mask;
                cap_read <= legal && !HWRITE;
                cap_write <= legal && HWRITE;
                cnt <= 3'(WAIT_STATES - 1);
                state <= !legal ? ERR1 : (WAIT_STATES > 0 ? WAIT : DATA);
            end else begin
                state <= state == WAIT ? (cnt == 3'd0 ? DATA : WAIT) : state == ERR1 ? ERR2 : IDLE;
                if (state == WAIT) cnt <= cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_mfp_ahb_lite_slave_frontend.sv
// tb_mfp_ahb_lite_slave_frontend: directed bench over four parameterisations of the AHB-Lite slave front-end
module tb_mfp_ahb_lite_slave_frontend;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] haddr = '0;
    logic [2:0] hsize = '0;
    logic [1:0] htrans = '0;
    logic hwrite = 1'b0;
    logic [63:0] hwdata = '0;
    logic [3:0] sel = '0;
    int tests = 0, fails = 0;

    logic [31:0] rdata0, wd0, mrd0;
    logic rdy0, resp0, re0, we0;
    logic [29:0] ra0, wa0;
    logic [3:0] wm0;
    logic [31:0] ram0 [0:3];

    logic [63:0] rdata1, wd1;
    logic rdy1, resp1, re1, we1;
    logic [28:0] ra1, wa1;
    logic [7:0] wm1;

    logic [31:0] rdata2, wd2, mrd2;
    logic rdy2, resp2, re2, we2;
    logic [29:0] ra2, wa2;
    logic [3:0] wm2;

    logic [31:0] rdata3, wd3;
    logic rdy3, resp3, re3, we3;
    logic [29:0] ra3, wa3;
    logic [3:0] wm3;

    always #5 clk = ~clk;

    mfp_ahb_lite_slave_frontend #(.DATA_WIDTH(32), .WAIT_STATES(0), .ERR_ON_MISALIGN(1'b1)) d0 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite),
        .HSEL(sel[0]), .HREADY(rdy0), .HWDATA(hwdata[31:0]), .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0),
        .mem_read_enable(re0), .mem_read_addr(ra0), .mem_read_data(mrd0), .mem_write_enable(we0),
        .mem_write_addr(wa0), .mem_write_mask(wm0), .mem_write_data(wd0));

    mfp_ahb_lite_slave_frontend #(.DATA_WIDTH(64), .WAIT_STATES(0), .ERR_ON_MISALIGN(1'b1)) d1 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite),
        .HSEL(sel[1]), .HREADY(rdy1), .HWDATA(hwdata), .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1),
        .mem_read_enable(re1), .mem_read_addr(ra1), .mem_read_data(64'h0), .mem_write_enable(we1),
        .mem_write_addr(wa1), .mem_write_mask(wm1), .mem_write_data(wd1));

    mfp_ahb_lite_slave_frontend #(.DATA_WIDTH(32), .WAIT_STATES(3), .ERR_ON_MISALIGN(1'b1)) d2 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite),
        .HSEL(sel[2]), .HREADY(rdy2), .HWDATA(hwdata[31:0]), .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2),
        .mem_read_enable(re2), .mem_read_addr(ra2), .mem_read_data(mrd2), .mem_write_enable(we2),
        .mem_write_addr(wa2), .mem_write_mask(wm2), .mem_write_data(wd2));

    mfp_ahb_lite_slave_frontend #(.DATA_WIDTH(32), .WAIT_STATES(0), .ERR_ON_MISALIGN(1'b0)) d3 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite),
        .HSEL(sel[3]), .HREADY(rdy3), .HWDATA(hwdata[31:0]), .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3),
        .mem_read_enable(re3), .mem_read_addr(ra3), .mem_read_data(32'h0), .mem_write_enable(we3),
        .mem_write_addr(wa3), .mem_write_mask(wm3), .mem_write_data(wd3));

    // sync-read RAM behind d0: a same-edge read returns the old word
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) ram0[i] <= 32'h0;
            ram0[1] <= 32'h5566_7788;
            mrd0 <= 32'h0;
        end else begin
            if (re0) mrd0 <= ram0[ra0[1:0]];
            if (we0) for (int i = 0; i < 4; i++) if (wm0[i]) ram0[wa0[1:0]][i*8 +: 8] <= wd0[i*8 +: 8];
        end
    end

    // memory behind d2 returns a pattern derived from the word address
    always @(posedge clk) begin
        if (!rst_n) mrd2 <= 32'h0;
        else if (re2) mrd2 <= 32'hC0DE_0000 | {2'b00, ra2};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [3:0] s, input logic [1:0] t, input logic w, input logic [31:0] a,
                       input logic [2:0] z, input logic [63:0] d);
        @(negedge clk);
        sel = s; htrans = t; hwrite = w; haddr = a; hsize = z; hwdata = d;
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdy0", rdy0, 1); chk("rst_resp0", resp0, 0); chk("rst_rdata0", rdata0, 0);
        chk("rst_we0", we0, 0); chk("rst_re0", re0, 0); chk("rst_rdy2", rdy2, 1);
        @(negedge clk);
        rst_n = 1'b1;
        // write 0x1000 then back-to-back read of the same word
        bus(4'h1, 2'b10, 1, 32'h1000, 3'd2, 64'h0);
        chk("fw_a_re0", re0, 0); chk("fw_a_rdy0", rdy0, 1);
        bus(4'h1, 2'b10, 0, 32'h1000, 3'd2, 64'hDEAD_BEEF);
        chk("fw_b_rdy0", rdy0, 1); chk("fw_b_re0", re0, 1); chk("fw_b_ra0", ra0, 30'h400);
        chk("fw_b_rdata0", rdata0, 0); chk("fw_b_we0", we0, 0);
        bus(4'h1, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("fw_c_rdy0", rdy0, 1); chk("fw_c_rdata0", rdata0, 32'hDEAD_BEEF); chk("fw_c_we0", we0, 1);
        chk("fw_c_wa0", wa0, 30'h400); chk("fw_c_wm0", wm0, 4'hF); chk("fw_c_wd0", wd0, 32'hDEAD_BEEF);
        bus(4'h1, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("fw_d_we0", we0, 0); chk("fw_d_rdata0", rdata0, 0);
        // plain read of the same word now comes from RAM
        bus(4'h1, 2'b10, 0, 32'h1000, 3'd2, 64'h0);
        bus(4'h1, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("ram_rdata0", rdata0, 32'hDEAD_BEEF);
        // upper halfword write, idle, then read colliding with the commit
        bus(4'h1, 2'b10, 1, 32'h1006, 3'd1, 64'h0);
        bus(4'h1, 2'b00, 0, 32'h0, 3'd2, 64'hCAFE_0000);
        bus(4'h1, 2'b10, 0, 32'h1004, 3'd2, 64'h0);
        chk("col_we0", we0, 1); chk("col_wm0", wm0, 4'b1100); chk("col_wa0", wa0, 30'h401); chk("col_re0", re0, 1);
        bus(4'h1, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("col_rdata0", rdata0, 32'hCAFE_7788);
        // HSIZE=3 on a 32-bit bus
        bus(4'h1, 2'b10, 1, 32'h0, 3'd3, 64'h0);
        chk("sz_re0", re0, 0); chk("sz_rdy0", rdy0, 1);
        bus(4'h1, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("sz_e1_rdy0", rdy0, 0); chk("sz_e1_resp0", resp0, 1);
        bus(4'h1, 2'b10, 0, 32'h1000, 3'd2, 64'h0);
        chk("sz_e2_rdy0", rdy0, 1); chk("sz_e2_resp0", resp0, 1); chk("sz_e2_re0", re0, 0); chk("sz_e2_we0", we0, 0);
        bus(4'h1, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("sz_end_resp0", resp0, 0); chk("sz_end_rdata0", rdata0, 0); chk("sz_end_we0", we0, 0);
        // misaligned halfword write with ERROR enabled
        bus(4'h1, 2'b10, 1, 32'h3001, 3'd1, 64'h0);
        bus(4'h1, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("mis_e1_rdy0", rdy0, 0); chk("mis_e1_resp0", resp0, 1);
        bus(4'h1, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("mis_e2_rdy0", rdy0, 1); chk("mis_e2_resp0", resp0, 1); chk("mis_e2_we0", we0, 0);
        bus(4'h1, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("mis_end_we0", we0, 0); chk("mis_end_resp0", resp0, 0);
        // BUSY with HSEL
        bus(4'h1, 2'b01, 0, 32'h1000, 3'd2, 64'h0);
        chk("busy_rdy0", rdy0, 1); chk("busy_resp0", resp0, 0); chk("busy_re0", re0, 0);
        bus(4'h0, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("busy_n_rdy0", rdy0, 1); chk("busy_n_rdata0", rdata0, 0); chk("busy_n_we0", we0, 0);
        // misaligned halfword write with forced alignment
        bus(4'h8, 2'b10, 1, 32'h3001, 3'd1, 64'h0);
        bus(4'h8, 2'b00, 0, 32'h0, 3'd2, 64'hBEEF);
        chk("al_rdy3", rdy3, 1); chk("al_resp3", resp3, 0);
        bus(4'h0, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("al_we3", we3, 1); chk("al_wm3", wm3, 4'b0011); chk("al_wa3", wa3, 30'hC00); chk("al_wd3", wd3, 32'hBEEF);
        // 64-bit byte then pipelined halfword write
        bus(4'h2, 2'b10, 1, 32'h2005, 3'd0, 64'h0);
        bus(4'h2, 2'b10, 1, 32'h2006, 3'd1, 64'h0000_AB00_0000_0000);
        chk("w64_rdy1", rdy1, 1);
        bus(4'h2, 2'b00, 0, 32'h0, 3'd2, 64'h1234_0000_0000_0000);
        chk("w64_b_we1", we1, 1); chk("w64_b_wm1", wm1, 8'b0010_0000); chk("w64_b_wa1", wa1, 29'h400);
        chk("w64_b_wd1", wd1, 64'h0000_AB00_0000_0000);
        bus(4'h0, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("w64_h_we1", we1, 1); chk("w64_h_wm1", wm1, 8'b1100_0000); chk("w64_h_wa1", wa1, 29'h400);
        chk("w64_h_wd1", wd1, 64'h1234_0000_0000_0000);
        bus(4'h0, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("w64_end_we1", we1, 0);
        // three wait states on a read of 0x0
        bus(4'h4, 2'b10, 0, 32'h0, 3'd2, 64'h0);
        chk("ws_a_re2", re2, 0); chk("ws_a_rdy2", rdy2, 1);
        bus(4'h4, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("ws_w1_rdy2", rdy2, 0); chk("ws_w1_re2", re2, 0);
        bus(4'h4, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("ws_w2_rdy2", rdy2, 0); chk("ws_w2_re2", re2, 0);
        bus(4'h4, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("ws_w3_rdy2", rdy2, 0); chk("ws_w3_re2", re2, 1); chk("ws_w3_ra2", ra2, 0);
        bus(4'h4, 2'b00, 0, 32'h0, 3'd2, 64'h0);
        chk("ws_d_rdy2", rdy2, 1); chk("ws_d_resp2", resp2, 0); chk("ws_d_rdata2", rdata2, 32'hC0DE_0000);
        // reset in the middle of a waited write
        bus(4'h4, 2'b10, 1, 32'h10, 3'd2, 64'h0);
        bus(4'h4, 2'b00, 0, 32'h0, 3'd2, 64'h1111_2222);
        chk("rw_rdy2", rdy2, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_rdy2", rdy2, 1); chk("ar_resp2", resp2, 0); chk("ar_rdata2", rdata2, 0);
        chk("ar_we2", we2, 0); chk("ar_re2", re2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus(4'h4, 2'b00, 0, 32'h0, 3'd2, 64'h1111_2222);
            chk("post_we2", we2, 0); chk("post_rdy2", rdy2, 1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
